rs_enc_lfsr: RTL



---
 rtl/rs_enc_lfsr.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/rs_enc_lfsr.sv
`timescale 1ns/1ps
// Systematic RS(K+4,K) encoder over GF(2^8) (poly 0x11D, roots alpha^0..alpha^3), LFSR form.
// Define RS_ENC_SYN_CHK_EN to add an output-side syndrome self-check driving chk_err.
module rs_enc_lfsr #(
  parameter int unsigned K  = 251,
  parameter int unsigned CW = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_par,
  output logic       out_last
`ifdef RS_ENC_SYN_CHK_EN
  ,
  output logic       chk_err
`endif
);

  typedef enum logic [0:0] {StData, StParity} state_e;

  localparam logic [CW-1:0] LastData = CW'(K - 1);
  localparam logic [CW-1:0] LastPar  = CW'(3);

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
  endfunction

  // Constant operands fold this into a plain XOR network.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = gf_xtime(t);
    end
    return p;
  endfunction

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    r0_q, r1_q, r2_q, r3_q;
  logic          slot_free;
  logic          accept;
  logic [7:0]    fb;

  assign slot_free = ~out_valid | out_ready;
  // Gated by rstn so no symbol is offered as accepted while reset is held.
  assign in_ready  = rstn & (state_q == StData) & slot_free;
  assign accept    = in_valid & in_ready;
  assign fb        = in_data ^ r3_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StData;
      cnt_q     <= '0;
      r0_q      <= 8'h00;
      r1_q      <= 8'h00;
      r2_q      <= 8'h00;
      r3_q      <= 8'h00;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_par   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      unique case (state_q)
        StData: begin
          if (accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            out_par   <= 1'b0;
            out_last  <= 1'b0;
            r3_q      <= r2_q ^ gf_mul(fb, 8'h0F);
            r2_q      <= r1_q ^ gf_mul(fb, 8'h36);
            r1_q      <= r0_q ^ gf_mul(fb, 8'h78);
            r0_q      <= gf_mul(fb, 8'h40);
            if (cnt_q == LastData) begin
              cnt_q   <= '0;
              state_q <= StParity;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        StParity: begin
          if (slot_free) begin
            out_data  <= r3_q;
            out_valid <= 1'b1;
            out_par   <= 1'b1;
            r3_q      <= r2_q;
            r2_q      <= r1_q;
            r1_q      <= r0_q;
            r0_q      <= 8'h00;
            if (cnt_q == LastPar) begin
              out_last <= 1'b1;
              cnt_q    <= '0;
              state_q  <= StData;
            end else begin
              out_last <= 1'b0;
              cnt_q    <= cnt_q + CW'(1);
            end
          end
        end
        default: state_q <= StData;
      endcase
    end
  end

`ifdef RS_ENC_SYN_CHK_EN
  logic [7:0] syn_q  [4];
  logic [7:0] syn_nx [4];
  logic       hs;
  logic       syn_nz;

  assign hs = out_valid & out_ready;

  // Horner evaluation of the emitted codeword at alpha^j, highest degree first.
  always_comb begin
    syn_nz = 1'b0;
    for (int j = 0; j < 4; j++) begin
      syn_nx[j] = gf_mul(syn_q[j], 8'(1 << j)) ^ out_data;
      syn_nz    = syn_nz | (syn_nx[j] != 8'h00);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chk_err <= 1'b0;
      for (int j = 0; j < 4; j++) syn_q[j] <= 8'h00;
    end else begin
      chk_err <= hs & out_last & syn_nz;
      if (hs) begin
        for (int j = 0; j < 4; j++) syn_q[j] <= out_last ? 8'h00 : syn_nx[j];
      end
    end
  end
`endif

endmodule
